reset_sequencer: RTL and testbench

Staged reset release controller that sits directly downstream of the reset synchronizer. It takes the synchronized active-low system reset and drives a set of per-domain reset outputs. On reset release it first holds every domain in reset for a fixed period. It then releases the domains one at a time, in index order, waiting for each domain's ready acknowledge (or a timeout) before releasing the next. A software reset request re-runs the whole sequence without a system reset.

---
 rtl/reset_sequencer_pkg.sv | 13 +
 rtl/reset_sequencer.sv | 151 +++++++++++++++
 tb/tb_reset_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and widths for the staged reset release controller.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CntWidth = 8;
    localparam int IdxWidth = 3;

endpackage

// File: rtl/reset_sequencer.sv
// Staged reset release: hold all domains, then release them one by one in index
// order, each gated on its ready acknowledge or a timeout.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NumStages     = 3,
    parameter int HoldCycles    = 16,
    parameter int TimeoutCycles = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic [NumStages-1:0] ready_in,
    output logic [NumStages-1:0] stage_rst_n,
    output logic                 busy,
    output logic                 done,
    output logic [NumStages-1:0] err
);

    if (NumStages < 1 || NumStages > 8) begin : g_bad_num_stages
        $error("reset_sequencer: NumStages must be in 1..8");
    end
    if (HoldCycles < 1 || HoldCycles > 255) begin : g_bad_hold
        $error("reset_sequencer: HoldCycles must be in 1..255");
    end
    if (TimeoutCycles < 1 || TimeoutCycles > 255) begin : g_bad_timeout
        $error("reset_sequencer: TimeoutCycles must be in 1..255");
    end

    localparam logic [CntWidth-1:0] HoldLoad    = CntWidth'(HoldCycles - 1);
    localparam logic [CntWidth-1:0] TimeoutLoad = CntWidth'(TimeoutCycles - 1);
    localparam logic [IdxWidth-1:0] LastIdx     = IdxWidth'(NumStages - 1);

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [IdxWidth-1:0]   idx_q, idx_d;
    logic [NumStages-1:0]  stage_rst_n_q, stage_rst_n_d;
    logic [NumStages-1:0]  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  ready_sel;
    logic                  cnt_zero;
    logic                  advance;
    logic                  timed_out;

    // Looped select keeps the index width independent of NumStages.
    always_comb begin
        ready_sel = 1'b0;
        for (int k = 0; k < NumStages; k++) begin
            if (k == int'(idx_q)) ready_sel = ready_in[k];
        end
    end

    assign cnt_zero  = (cnt_q == '0);
    assign advance   = ready_sel | cnt_zero;
    assign timed_out = cnt_zero & ~ready_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (req) begin
            state_d = HOLD;
        end else begin
            unique case (state_q)
                HOLD:    if (cnt_zero) state_d = WAIT;
                WAIT:    if (advance && idx_q == LastIdx) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = HOLD;
            endcase
        end
    end

    always_comb begin
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        stage_rst_n_d = stage_rst_n_q;
        err_d         = err_q;
        busy_d        = busy_q;
        done_d        = done_q;
        if (req) begin
            cnt_d         = HoldLoad;
            idx_d         = '0;
            stage_rst_n_d = '0;
            err_d         = '0;
            busy_d        = 1'b1;
            done_d        = 1'b0;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - CntWidth'(1);
                    end else begin
                        stage_rst_n_d[0] = 1'b1;
                        idx_d            = '0;
                        cnt_d            = TimeoutLoad;
                    end
                end
                WAIT: begin
                    if (advance) begin
                        for (int k = 0; k < NumStages; k++) begin
                            if (timed_out && k == int'(idx_q)) err_d[k] = 1'b1;
                            if (idx_q != LastIdx && k == int'(idx_q) + 1) stage_rst_n_d[k] = 1'b1;
                        end
                        if (idx_q == LastIdx) begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IdxWidth'(1);
                            cnt_d = TimeoutLoad;
                        end
                    end else begin
                        cnt_d = cnt_q - CntWidth'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= HoldLoad;
            idx_q         <= '0;
            stage_rst_n_q <= '0;
            err_q         <= '0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            stage_rst_n_q <= stage_rst_n_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign stage_rst_n = stage_rst_n_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer with NumStages=3, HoldCycles=4, TimeoutCycles=8.
module tb_reset_sequencer;

    typedef struct {
        logic       rst_n;
        logic       req;
        logic [2:0] rdy;
        logic [2:0] stg;
        logic       bsy;
        logic       dn;
        logic [2:0] er;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [2:0] ready_in = 3'b000;
    logic [2:0] stage_rst_n;
    logic       busy;
    logic       done;
    logic [2:0] err;

    int   total = 0;
    int   bad = 0;
    int   step_no = 0;
    vec_t vecs[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    reset_sequencer #(
        .NumStages    (3),
        .HoldCycles   (4),
        .TimeoutCycles(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .ready_in   (ready_in),
        .stage_rst_n(stage_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic v(input logic r, input logic q, input logic [2:0] rdy,
                     input logic [2:0] s, input logic b, input logic d, input logic [2:0] e);
        vec_t t;
        t.rst_n = r; t.req = q; t.rdy = rdy; t.stg = s; t.bsy = b; t.dn = d; t.er = e;
        vecs.push_back(t);
    endtask

    task automatic rep(input int n, input logic [2:0] rdy, input logic [2:0] s, input logic [2:0] e);
        for (int i = 0; i < n; i++) v(1'b1, 1'b0, rdy, s, 1'b1, 1'b0, e);
    endtask

    // Edges 1..7 after a restart with every ready tied high.
    task automatic clean_run();
        rep(3, 3'b111, 3'b000, 3'b000);
        rep(1, 3'b111, 3'b001, 3'b000);
        rep(1, 3'b111, 3'b011, 3'b000);
        rep(1, 3'b111, 3'b111, 3'b000);
        v(1'b1, 1'b0, 3'b111, 3'b111, 1'b0, 1'b1, 3'b000);
    endtask

    task automatic step(input vec_t t);
        vec_t exp;
        @(negedge clk);
        rst_n    = t.rst_n;
        req      = t.req;
        ready_in = t.rdy;
        sb.push_back(t);
        @(posedge clk);
        #1;
        step_no++;
        exp = sb.pop_front();
        total++;
        if (stage_rst_n !== exp.stg || busy !== exp.bsy || done !== exp.dn || err !== exp.er) begin
            bad++;
            $display("FAIL step%0d: got stg=%b busy=%b done=%b err=%b, want stg=%b busy=%b done=%b err=%b",
                     step_no, stage_rst_n, busy, done, err, exp.stg, exp.bsy, exp.dn, exp.er);
        end
    endtask

    task automatic hstep(input logic r, input logic q, input logic [2:0] rdy,
                         input logic [2:0] s, input logic b, input logic d, input logic [2:0] e);
        vec_t t;
        t.rst_n = r; t.req = q; t.rdy = rdy; t.stg = s; t.bsy = b; t.dn = d; t.er = e;
        step(t);
    endtask

    task automatic hrep(input int n, input logic [2:0] rdy, input logic [2:0] s, input logic [2:0] e);
        for (int i = 0; i < n; i++) hstep(1'b1, 1'b0, rdy, s, 1'b1, 1'b0, e);
    endtask

    initial begin
        // Power-up reset, then a clean release with all readys high.
        for (int i = 0; i < 3; i++) v(1'b0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 3'b000);
        clean_run();
        // DONE ignores dropped readys.
        v(1'b1, 1'b0, 3'b000, 3'b111, 1'b0, 1'b1, 3'b000);
        v(1'b1, 1'b0, 3'b000, 3'b111, 1'b0, 1'b1, 3'b000);
        // Restart; stage 1 never acknowledges and times out.
        v(1'b1, 1'b1, 3'b101, 3'b000, 1'b1, 1'b0, 3'b000);
        rep(3, 3'b101, 3'b000, 3'b000);
        rep(1, 3'b101, 3'b001, 3'b000);
        rep(1, 3'b101, 3'b011, 3'b000);
        rep(7, 3'b101, 3'b011, 3'b000);
        rep(1, 3'b101, 3'b111, 3'b010);
        v(1'b1, 1'b0, 3'b101, 3'b111, 1'b0, 1'b1, 3'b010);
        // req after done clears err and repeats the clean timing.
        v(1'b1, 1'b1, 3'b111, 3'b000, 1'b1, 1'b0, 3'b000);
        clean_run();

        foreach (vecs[i]) step(vecs[i]);

        // ready_in[0] arrives on the same cycle the timeout counter hits zero.
        hstep(1'b1, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000);
        hrep(3, 3'b000, 3'b000, 3'b000);
        hrep(1, 3'b000, 3'b001, 3'b000);
        hrep(7, 3'b000, 3'b001, 3'b000);
        hrep(1, 3'b001, 3'b011, 3'b000);
        hrep(1, 3'b111, 3'b111, 3'b000);
        hstep(1'b1, 1'b0, 3'b111, 3'b111, 1'b0, 1'b1, 3'b000);

        // req collides with ready_in[1] while waiting on stage 1.
        hstep(1'b1, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000);
        hrep(3, 3'b000, 3'b000, 3'b000);
        hrep(1, 3'b000, 3'b001, 3'b000);
        hrep(1, 3'b001, 3'b011, 3'b000);
        hrep(2, 3'b000, 3'b011, 3'b000);
        hstep(1'b1, 1'b1, 3'b010, 3'b000, 1'b1, 1'b0, 3'b000);
        hrep(3, 3'b000, 3'b000, 3'b000);
        hrep(3, 3'b000, 3'b001, 3'b000);

        // rst_n drops while waiting on stage 2 with err set; rst_n beats req.
        hstep(1'b1, 1'b1, 3'b001, 3'b000, 1'b1, 1'b0, 3'b000);
        hrep(3, 3'b001, 3'b000, 3'b000);
        hrep(1, 3'b001, 3'b001, 3'b000);
        hrep(1, 3'b001, 3'b011, 3'b000);
        hrep(7, 3'b001, 3'b011, 3'b000);
        hrep(2, 3'b001, 3'b111, 3'b010);
        hstep(1'b0, 1'b0, 3'b001, 3'b000, 1'b1, 1'b0, 3'b000);
        hstep(1'b0, 1'b1, 3'b111, 3'b000, 1'b1, 1'b0, 3'b000);
        hrep(3, 3'b111, 3'b000, 3'b000);
        hrep(1, 3'b111, 3'b001, 3'b000);
        hrep(1, 3'b111, 3'b011, 3'b000);
        hrep(1, 3'b111, 3'b111, 3'b000);
        hstep(1'b1, 1'b0, 3'b111, 3'b111, 1'b0, 1'b1, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
